// File: rtl/cory_mux4_rr.sv
// cory_mux4_rr: four-input round-robin merger feeding a 2-entry output FIFO.
// Every output beat carries its 2-bit source index on o_z_s for routing responses back.
module cory_mux4_rr #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_a0_v,
    input  logic         i_a1_v,
    input  logic         i_a2_v,
    input  logic         i_a3_v,
    input  logic [N-1:0] i_a0_d,
    input  logic [N-1:0] i_a1_d,
    input  logic [N-1:0] i_a2_d,
    input  logic [N-1:0] i_a3_d,
    output logic         o_a0_r,
    output logic         o_a1_r,
    output logic         o_a2_r,
    output logic         o_a3_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    output logic [1:0]   o_z_s,
    input  logic         i_z_r
);
    localparam int W = N + 2;

    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   count_q, count_d;
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic [W-1:0] mem_q [2];

    logic [3:0]   valid;
    logic [N-1:0] data [4];
    logic [1:0]   grant;
    logic [1:0]   idx;
    logic         any_v;
    logic         space;
    logic         push;
    logic         pop;

    assign valid   = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
    assign data[0] = i_a0_d;
    assign data[1] = i_a1_d;
    assign data[2] = i_a2_d;
    assign data[3] = i_a3_d;

    assign any_v = |valid;
    assign space = (count_q != 2'd2);
    assign push  = space && any_v && !reset;
    assign pop   = (count_q != 2'd0) && i_z_r;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant = ptr_q;
        idx   = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (valid[idx]) begin
                grant = idx;
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            ptr_d = grant + 2'd1;
            wr_d  = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            count_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            // NOTE: FIFO storage is reset so the idle head reads 0 rather than X.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            if (push) begin
                mem_q[wr_q] <= {grant, data[grant]};
            end
        end
    end

    assign o_z_v          = (count_q != 2'd0);
    assign {o_z_s, o_z_d} = mem_q[rd_q];

    assign o_a0_r = push && (grant == 2'd0);
    assign o_a1_r = push && (grant == 2'd1);
    assign o_a2_r = push && (grant == 2'd2);
    assign o_a3_r = push && (grant == 2'd3);
endmodule

// File: tb/tb_cory_mux4_rr.sv
// tb_cory_mux4_rr: directed vectors plus a sparse random phase, checked every cycle
// against a queue-based model of the round-robin merger.
module tb_cory_mux4_rr;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   vin;
    logic [N-1:0] din [4];
    logic         i_z_r;
    logic         o_a0_r, o_a1_r, o_a2_r, o_a3_r;
    logic         o_z_v;
    logic [N-1:0] o_z_d;
    logic [1:0]   o_z_s;
    logic [3:0]   rdy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;

    // Model state: priority pointer, FIFO contents in order, per-input wait counts.
    int             m_ptr = 0;
    logic [N+1:0]   q [$];
    int             wait_cnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    cory_mux4_rr #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_a0_v (vin[0]),
        .i_a1_v (vin[1]),
        .i_a2_v (vin[2]),
        .i_a3_v (vin[3]),
        .i_a0_d (din[0]),
        .i_a1_d (din[1]),
        .i_a2_d (din[2]),
        .i_a3_d (din[3]),
        .o_a0_r (o_a0_r),
        .o_a1_r (o_a1_r),
        .o_a2_r (o_a2_r),
        .o_a3_r (o_a3_r),
        .o_z_v  (o_z_v),
        .o_z_d  (o_z_d),
        .o_z_s  (o_z_s),
        .i_z_r  (i_z_r)
    );

    assign rdy = {o_a3_r, o_a2_r, o_a1_r, o_a0_r};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input the model will grant this cycle, or -1 if none.
    function automatic int exp_grant();
        if (reset || q.size() >= 2) return -1;
        for (int i = 0; i < 4; i++) begin
            if (vin[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int g;
        if (reset) begin
            q.delete();
            m_ptr = 0;
            for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
        end else begin
            g = exp_grant();
            if (q.size() != 0 && i_z_r) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back({2'(g), din[g]});
                m_ptr = (g + 1) % 4;
                for (int k = 0; k < 4; k++) begin
                    if (k == g) begin
                        check("fairness_wait_gt3", 32'(wait_cnt[k] > 3), 0);
                        wait_cnt[k] = 0;
                    end else if (vin[k]) begin
                        wait_cnt[k]++;
                    end else begin
                        wait_cnt[k] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        g = exp_grant();
        check("ready_vec", 32'(rdy), (g >= 0) ? 32'(4'b0001 << g) : 32'd0);
        check("z_valid", 32'(o_z_v), 32'(q.size() != 0));
        if (q.size() != 0) check("z_head", 32'({o_z_s, o_z_d}), 32'(q[0]));
    end

    initial begin
        logic [3:0] fire;
        reset = 1'b1;
        vin   = '0;
        i_z_r = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = '0;

        // Reset state, with inputs valid while reset is held.
        tick(); tick();
        vin = 4'hF;
        @(negedge clk);
        check("rst_ready", 32'(rdy), 0);
        check("rst_zv", 32'(o_z_v), 0);
        check("rst_zd", 32'(o_z_d), 0);
        check("rst_zs", 32'(o_z_s), 0);
        tick();

        // Single source: input 2 with 0x5A.
        reset   = 1'b0;
        i_z_r   = 1'b1;
        vin     = 4'b0100;
        din[2]  = 8'h5A;
        @(negedge clk);
        check("single_ready", 32'(rdy), 32'h4);
        tick();
        vin = '0;
        @(negedge clk);
        check("single_zv", 32'(o_z_v), 1);
        check("single_zd", 32'(o_z_d), 32'h5A);
        check("single_zs", 32'(o_z_s), 2);
        tick();

        // Pointer now 3: inputs 1 and 3 valid grants 3, then 0 beats 3 after the wrap.
        vin    = 4'b1010;
        din[1] = 8'h21;
        din[3] = 8'h23;
        @(negedge clk);
        check("ptr3_grant3", 32'(rdy), 32'h8);
        tick();
        vin    = 4'b1001;
        din[0] = 8'h20;
        @(negedge clk);
        check("wrap_grant0", 32'(rdy), 32'h1);
        check("wrap_prev_zs", 32'(o_z_s), 3);
        check("wrap_prev_zd", 32'(o_z_d), 32'h23);
        tick();
        vin = '0;
        @(negedge clk);
        check("wrap_zs", 32'(o_z_s), 0);
        check("wrap_zd", 32'(o_z_d), 32'h20);
        tick(); tick();

        // All four valid, full throughput.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = 8'(8'h10 + k);
        vin = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            check("rr_zv", 32'(o_z_v), 1);
            check("rr_zs", 32'(o_z_s), 32'(i % 4));
            check("rr_zd", 32'(o_z_d), 32'(8'h10 + i % 4));
        end
        tick();
        vin = '0;
        tick(); tick();

        // Backpressure: two accepts then stall, drain resumes at index 2.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_z_r = 1'b0;
        vin   = 4'hF;
        tick(); tick();
        @(negedge clk);
        check("bp_ready_low", 32'(rdy), 0);
        check("bp_zv", 32'(o_z_v), 1);
        check("bp_zs", 32'(o_z_s), 0);
        tick(); tick();
        @(negedge clk);
        check("bp_hold_ready", 32'(rdy), 0);
        check("bp_hold_zs", 32'(o_z_s), 0);
        check("bp_hold_zd", 32'(o_z_d), 32'h10);
        tick();
        i_z_r = 1'b1;
        @(negedge clk);
        check("bp_full_ready", 32'(rdy), 0);
        tick();
        @(negedge clk);
        check("bp_rise_ready", 32'(rdy), 32'h4);
        check("bp_pop1_zs", 32'(o_z_s), 1);
        tick();
        @(negedge clk);
        check("bp_pop2_zs", 32'(o_z_s), 2);
        check("bp_pop2_zd", 32'(o_z_d), 32'h12);
        tick();
        vin = '0;
        tick(); tick(); tick();

        // Reset with the FIFO full, then arbitration restarts at input 0.
        i_z_r = 1'b0;
        vin   = 4'hF;
        tick(); tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_zv", 32'(o_z_v), 0);
        check("midrst_zd", 32'(o_z_d), 0);
        check("midrst_zs", 32'(o_z_s), 0);
        check("midrst_ready", 32'(rdy), 0);
        tick();
        reset = 1'b0;
        i_z_r = 1'b1;
        vin   = 4'b1010;
        @(negedge clk);
        check("midrst_grant1", 32'(rdy), 32'h2);
        tick();
        vin = '0;
        @(negedge clk);
        check("midrst_zs", 32'(o_z_s), 1);
        check("midrst_zd", 32'(o_z_d), 32'h11);
        tick(); tick();

        // Sparse random traffic; sources hold valid and data until accepted.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            fire = vin & rdy;
            if (o_z_v && i_z_r) n_pop++;
            tick();
            for (int k = 0; k < 4; k++) begin
                if (fire[k]) vin[k] = 1'b0;
                if (!vin[k] && $urandom_range(0, 99) < 30) begin
                    vin[k] = 1'b1;
                    din[k] = 8'($urandom_range(0, 255));
                end
            end
            i_z_r = ($urandom_range(0, 99) < 60);
        end
        vin   = '0;
        i_z_r = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("drain_empty", 32'(o_z_v), 0);
        check("rand_activity", 32'(n_pop > 1000), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
